sram_like_to_axi: RTL and testbench
===================================

SRAM_LIKE_TO_AXI -- requirements
Module: sram_like_to_axi

Interface
REQ-001 The block SHALL have no parameters; the bus is 32-bit address, 32-bit data, single beat, single outstanding transaction.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 areset  input  1  reset, synchronous and active-low.
REQ-004 sl_req  input  1  sram-like request from the upstream converter.
REQ-005 sl_wr  input  1  1 = write, 0 = read.
REQ-006 sl_size  input  2  0 = byte, 1 = half, 2 = word.
REQ-007 sl_addr  input  32  byte address.
REQ-008 sl_wdata  input  32  write data, already lane-aligned.
REQ-009 sl_rdata  output  32  read data, registered.
REQ-010 sl_addr_ok  output  1  request accepted this cycle.
REQ-011 sl_data_ok  output  1  one-cycle completion pulse.
REQ-012 araddr  output  32  read address.
REQ-013 arsize  output  3  {1'b0, size}.
REQ-014 arvalid  output  1  AR valid.
REQ-015 arready  input  1  AR ready.
REQ-016 rdata  input  32  read data.
REQ-017 rresp  input  2  read response.
REQ-018 rvalid  input  1  R valid.
REQ-019 rready  output  1  R ready.
REQ-020 awaddr  output  32  write address.
REQ-021 awsize  output  3  {1'b0, size}.
REQ-022 awvalid  output  1  AW valid.
REQ-023 awready  input  1  AW ready.
REQ-024 wdata  output  32  write data.
REQ-025 wstrb  output  4  byte strobes.
REQ-026 wvalid  output  1  W valid.
REQ-027 wready  input  1  W ready.
REQ-028 bresp  input  2  write response.
REQ-029 bvalid  input  1  B valid.
REQ-030 bready  output  1  B ready.

Function
REQ-031 The block SHALL implement states IDLE, AR, R, AW_W and B.
REQ-032 sl_addr_ok SHALL be combinational, equal to (state==IDLE) & sl_req; a request in any other state SHALL be ignored, and upstream holds it.
REQ-033 On accept, the block SHALL register addr, size, wr and wdata, and enter AR (read) or AW_W (write) at the next edge.
REQ-034 AR: arvalid=1 with stable araddr/arsize until the arready handshake, then R.
REQ-035 R: rready=1; on the rvalid handshake, sl_rdata<=rdata, sl_data_ok<=1 for exactly one cycle, state<=IDLE.
REQ-036 AW_W: awvalid and wvalid SHALL both assert on entry; each SHALL drop independently after its own handshake, tracked by aw_done/w_done flags; the state SHALL go to B at the edge where both are done, including the same-cycle case.
REQ-037 B: bready=1; on the bvalid handshake, sl_data_ok pulses one cycle and state<=IDLE; sl_rdata is unchanged.
REQ-038 Minimum latency with ready/valid always high: accept at cycle 0, AR/AW handshake at cycle 1, R/B handshake at cycle 2, sl_data_ok at cycle 3.
REQ-039 Valid outputs SHALL be driven from registers and state only, never combinationally from any ready input.
REQ-040 A new request MAY be accepted in the same cycle that sl_data_ok is high.
REQ-041 araddr/awaddr SHALL carry the unaligned sl_addr; wdata = registered sl_wdata.
REQ-042 wstrb: size 0 -> 4'b0001<<addr[1:0]; size 1 -> 4'b0011<<{addr[1],1'b0}; size 2 or 3 -> 4'b1111.
REQ-043 A non-zero rresp or bresp SHALL be ignored; the transaction completes normally and rdata is still returned.
REQ-044 rready and bready SHALL be 0 outside the R and B states.

Reset
REQ-045 With areset=0 at a posedge, the block SHALL set state=IDLE, all valid/ready outputs=0, sl_data_ok=0, sl_rdata=0, done flags=0, and captured payload=0.
REQ-046 Reset mid-transaction SHALL abandon it with no sl_data_ok; the system guarantees AXI quiescence.

Verification
REQ-047 Read word at 0x1000, slave ready=1 -> arvalid cycle 1, araddr=0x1000, arsize=2; sl_data_ok at cycle 3 with sl_rdata=rdata=0xDEADBEEF.
REQ-048 Byte write at 0x2003, wdata=0xAA000000 -> wstrb=4'b1000, awsize=0; B handshake -> one sl_data_ok pulse.
REQ-049 awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles with stable awaddr; enters B only after the AW handshake.
REQ-050 sl_req held high during R -> sl_addr_ok=0 until IDLE; accepted in the sl_data_ok cycle; back-to-back read-write-read completes in order.
REQ-051 areset asserted while in R with rvalid=0 -> next cycle all valids/readies=0, state IDLE, no sl_data_ok; rresp=2'b10 on a later read still yields sl_data_ok.

Source files
------------

// File: rtl/sram_like_to_axi_if.sv
// sram_like_to_axi_if: sram-like upstream port plus single-beat AXI master bus
interface sram_like_to_axi_if;
  logic        sl_req;
  logic        sl_wr;
  logic [1:0]  sl_size;
  logic [31:0] sl_addr;
  logic [31:0] sl_wdata;
  logic [31:0] sl_rdata;
  logic        sl_addr_ok;
  logic        sl_data_ok;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  modport master (
    input  sl_req, sl_wr, sl_size, sl_addr, sl_wdata,
    output sl_rdata, sl_addr_ok, sl_data_ok,
    output araddr, arsize, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );
  modport slave (
    output sl_req, sl_wr, sl_size, sl_addr, sl_wdata,
    input  sl_rdata, sl_addr_ok, sl_data_ok,
    input  araddr, arsize, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awsize, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/sram_like_to_axi.sv
// sram_like_to_axi: bridges single sram-like requests to single-beat AXI reads/writes
module sram_like_to_axi (
  input  logic              clk,
  input  logic              areset,
  sram_like_to_axi_if.master bus
);
  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B} state_t;
  state_t      state, state_nxt;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        aw_done, w_done;
  logic        r_hs, aw_hs, w_hs, b_hs, aw_fin, w_fin;
  logic        unused_resp;
  assign unused_resp     = ^{bus.rresp, bus.bresp};
  assign bus.sl_addr_ok  = state == IDLE && bus.sl_req;
  assign bus.arvalid     = state == AR;
  assign bus.rready      = state == R;
  assign bus.awvalid     = state == AW_W && !aw_done;
  assign bus.wvalid      = state == AW_W && !w_done;
  assign bus.bready      = state == B;
  assign bus.araddr      = addr_q;
  assign bus.awaddr      = addr_q;
  assign bus.arsize      = {1'b0, size_q};
  assign bus.awsize      = {1'b0, size_q};
  assign bus.wdata       = wdata_q;
  assign bus.wstrb       = size_q == 2'd0 ? 4'b0001 << addr_q[1:0] :
                           size_q == 2'd1 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign r_hs   = bus.rready && bus.rvalid;
  assign aw_hs  = bus.awvalid && bus.awready;
  assign w_hs   = bus.wvalid && bus.wready;
  assign b_hs   = bus.bready && bus.bvalid;
  // a channel counts as finished if it completed earlier or is completing now
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.sl_req) state_nxt = bus.sl_wr ? AW_W : AR;
      AR:      if (bus.arready) state_nxt = R;
      R:       if (bus.rvalid) state_nxt = IDLE;
      AW_W:    if (aw_fin && w_fin) state_nxt = B;
      B:       if (bus.bvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!areset) begin
      state          <= IDLE;
      addr_q         <= '0;
      size_q         <= '0;
      wdata_q        <= '0;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      bus.sl_rdata   <= '0;
      bus.sl_data_ok <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.sl_data_ok <= r_hs || b_hs;
      aw_done        <= aw_fin && !w_fin;
      w_done         <= w_fin && !aw_fin;
      if (r_hs) bus.sl_rdata <= bus.rdata;
      if (bus.sl_addr_ok) begin
        addr_q  <= bus.sl_addr;
        size_q  <= bus.sl_size;
        wdata_q <= bus.sl_wdata;
      end
    end
  end
endmodule

// File: tb/tb_sram_like_to_axi.sv
// tb_sram_like_to_axi: scoreboard bench with a reactive AXI slave model
module tb_sram_like_to_axi;
  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;
  sram_like_to_axi_if bus();
  sram_like_to_axi dut (.clk(clk), .areset(areset), .bus(bus));
  typedef struct packed {logic [31:0] addr; logic [2:0] size;} ax_t;
  typedef struct packed {logic [31:0] data; logic [3:0] strb;} w_t;
  ax_t         exp_ar[$], exp_aw[$];
  w_t          exp_w[$];
  logic [31:0] exp_done[$], rdata_q[$];
  int          tests = 0, fails = 0;
  int          aw_wait = 0, w_wait = 0;
  logic        r_hold = 1'b0;
  logic [1:0]  resp_val = 2'b00;
  logic [31:0] last_rd = '0;
  ax_t         m_ax;
  w_t          m_w;
  logic [31:0] m_d;

  function automatic logic [3:0] strb_of(input logic [1:0] s, input logic [31:0] a);
    case (s)
      2'd0:    strb_of = 4'b0001 << a[1:0];
      2'd1:    strb_of = a[1] ? 4'b1100 : 4'b0011;
      default: strb_of = 4'b1111;
    endcase
  endfunction

  // slave: samples handshakes at negedge, updates its outputs just after posedge
  initial begin
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, rst_seen, pend_r, got_aw, got_w;
    int aw_cnt, w_cnt;
    pend_r = 0; got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = '0; bus.rresp = '0;
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = '0;
    forever begin
      @(negedge clk);
      ar_hs = bus.arvalid && bus.arready;
      r_hs  = bus.rvalid && bus.rready;
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      b_hs  = bus.bvalid && bus.bready;
      rst_seen = !areset;
      @(posedge clk);
      #1;
      if (rst_seen) begin
        pend_r = 0; got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
        bus.rvalid = 0; bus.bvalid = 0; bus.awready = 0; bus.wready = 0; bus.arready = 0;
      end else begin
        bus.arready = 1;
        if (r_hs) pend_r = 0;
        if (ar_hs) begin
          pend_r = 1;
          bus.rdata = rdata_q.size() != 0 ? rdata_q.pop_front() : 32'hBAD0BAD0;
        end
        bus.rvalid = pend_r && !r_hold;
        bus.rresp  = resp_val;
        bus.bresp  = resp_val;
        if (aw_hs) got_aw = 1;
        if (w_hs) got_w = 1;
        if (b_hs) bus.bvalid = 0;
        if (got_aw && got_w) begin bus.bvalid = 1; got_aw = 0; got_w = 0; end
        if (bus.awvalid) begin bus.awready = aw_cnt >= aw_wait; aw_cnt++; end
        else begin bus.awready = 0; aw_cnt = 0; end
        if (bus.wvalid) begin bus.wready = w_cnt >= w_wait; w_cnt++; end
        else begin bus.wready = 0; w_cnt = 0; end
      end
    end
  end

  // scoreboard: every AXI handshake and completion is matched in order
  always @(negedge clk) if (areset) begin
    if (bus.arvalid && bus.arready) begin
      tests++;
      if (exp_ar.size() == 0) begin fails++; $display("FAIL sb_ar unexpected addr=%h", bus.araddr); end
      else begin
        m_ax = exp_ar.pop_front();
        if ({bus.araddr, bus.arsize} !== m_ax) begin
          fails++; $display("FAIL sb_ar got %h/%0d required %h/%0d", bus.araddr, bus.arsize, m_ax.addr, m_ax.size);
        end
      end
    end
    if (bus.awvalid && bus.awready) begin
      tests++;
      if (exp_aw.size() == 0) begin fails++; $display("FAIL sb_aw unexpected addr=%h", bus.awaddr); end
      else begin
        m_ax = exp_aw.pop_front();
        if ({bus.awaddr, bus.awsize} !== m_ax) begin
          fails++; $display("FAIL sb_aw got %h/%0d required %h/%0d", bus.awaddr, bus.awsize, m_ax.addr, m_ax.size);
        end
      end
    end
    if (bus.wvalid && bus.wready) begin
      tests++;
      if (exp_w.size() == 0) begin fails++; $display("FAIL sb_w unexpected data=%h", bus.wdata); end
      else begin
        m_w = exp_w.pop_front();
        if ({bus.wdata, bus.wstrb} !== m_w) begin
          fails++; $display("FAIL sb_w got %h/%b required %h/%b", bus.wdata, bus.wstrb, m_w.data, m_w.strb);
        end
      end
    end
    if (bus.sl_data_ok) begin
      tests++;
      if (exp_done.size() == 0) begin fails++; $display("FAIL sb_done unexpected sl_data_ok rdata=%h", bus.sl_rdata); end
      else begin
        m_d = exp_done.pop_front();
        if (bus.sl_rdata !== m_d) begin fails++; $display("FAIL sb_done sl_rdata got %h required %h", bus.sl_rdata, m_d); end
      end
    end
  end

  task automatic push_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd);
    if (wr) begin
      exp_aw.push_back({addr, 1'b0, size});
      exp_w.push_back({wd, strb_of(size, addr)});
      exp_done.push_back(last_rd);
    end else begin
      exp_ar.push_back({addr, 1'b0, size});
      rdata_q.push_back(rd);
      exp_done.push_back(rd);
      last_rd = rd;
    end
  endtask

  task automatic issue(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd);
    push_req(wr, size, addr, wd, rd);
    @(posedge clk); #1;
    bus.sl_req = 1; bus.sl_wr = wr; bus.sl_size = size; bus.sl_addr = addr; bus.sl_wdata = wd;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus.sl_addr_ok) break; end
    @(posedge clk); #1;
    bus.sl_req = 0;
  endtask

  task automatic test_reset();
    areset = 0;
    repeat (3) @(negedge clk);
    tests++;
    if ({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, bus.sl_data_ok, bus.sl_addr_ok} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl got %b required 0", {bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, bus.sl_data_ok, bus.sl_addr_ok});
    end
    tests++;
    if ({bus.sl_rdata, bus.araddr, bus.wdata} !== 96'b0) begin
      fails++; $display("FAIL reset_data got %h/%h/%h required 0", bus.sl_rdata, bus.araddr, bus.wdata);
    end
    @(posedge clk); #1;
    areset = 1;
    @(negedge clk);
    tests++;
    if ({bus.arvalid, bus.awvalid, bus.sl_addr_ok} !== 3'b0) begin
      fails++; $display("FAIL reset_idle got %b required 000", {bus.arvalid, bus.awvalid, bus.sl_addr_ok});
    end
  endtask

  task automatic test_read();
    push_req(0, 2'd2, 32'h1000, '0, 32'hDEADBEEF);
    @(posedge clk); #1;
    bus.sl_req = 1; bus.sl_wr = 0; bus.sl_size = 2'd2; bus.sl_addr = 32'h1000;
    @(negedge clk);
    tests++;
    if (bus.sl_addr_ok !== 1'b1) begin fails++; $display("FAIL read_accept addr_ok got %b required 1", bus.sl_addr_ok); end
    @(posedge clk); #1;
    bus.sl_req = 0;
    @(negedge clk);
    tests++;
    if ({bus.arvalid, bus.araddr, bus.arsize} !== {1'b1, 32'h1000, 3'd2}) begin
      fails++; $display("FAIL read_ar got %b/%h/%0d required 1/00001000/2", bus.arvalid, bus.araddr, bus.arsize);
    end
    @(negedge clk);
    tests++;
    if ({bus.arvalid, bus.rready} !== 2'b01) begin fails++; $display("FAIL read_r got %b required 01", {bus.arvalid, bus.rready}); end
    @(negedge clk);
    tests++;
    if ({bus.sl_data_ok, bus.sl_rdata} !== {1'b1, 32'hDEADBEEF}) begin
      fails++; $display("FAIL read_done got %b/%h required 1/deadbeef", bus.sl_data_ok, bus.sl_rdata);
    end
    @(negedge clk);
    tests++;
    if ({bus.sl_data_ok, bus.rready} !== 2'b00) begin fails++; $display("FAIL read_pulse got %b required 00", {bus.sl_data_ok, bus.rready}); end
  endtask

  task automatic test_byte_write();
    int pulses = 0;
    logic [3:0] seen_strb = 'x;
    logic [2:0] seen_size = 'x;
    issue(1, 2'd0, 32'h2003, 32'hAA000000, '0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.sl_data_ok) pulses++;
      if (bus.wvalid && bus.wready) seen_strb = bus.wstrb;
      if (bus.awvalid && bus.awready) seen_size = bus.awsize;
    end
    tests++;
    if ({seen_strb, seen_size} !== {4'b1000, 3'd0}) begin
      fails++; $display("FAIL bwrite_strb got %b/%0d required 1000/0", seen_strb, seen_size);
    end
    tests++;
    if (pulses != 1) begin fails++; $display("FAIL bwrite_pulses got %0d required 1", pulses); end
  endtask

  task automatic test_aw_delay();
    aw_wait = 2;
    push_req(1, 2'd1, 32'h3002, 32'h12340000, '0);
    @(posedge clk); #1;
    bus.sl_req = 1; bus.sl_wr = 1; bus.sl_size = 2'd1; bus.sl_addr = 32'h3002; bus.sl_wdata = 32'h12340000;
    @(negedge clk);
    @(posedge clk); #1;
    bus.sl_req = 0;
    @(negedge clk);
    tests++;
    if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b110) begin fails++; $display("FAIL awd_c1 got %b required 110", {bus.awvalid, bus.wvalid, bus.bready}); end
    @(negedge clk);
    tests++;
    if ({bus.awvalid, bus.wvalid, bus.bready, bus.awaddr} !== {3'b100, 32'h3002}) begin
      fails++; $display("FAIL awd_c2 got %b/%h required 100/00003002", {bus.awvalid, bus.wvalid, bus.bready}, bus.awaddr);
    end
    @(negedge clk);
    tests++;
    if ({bus.awvalid, bus.awready, bus.bready, bus.awaddr} !== {3'b110, 32'h3002}) begin
      fails++; $display("FAIL awd_c3 got %b/%h required 110/00003002", {bus.awvalid, bus.awready, bus.bready}, bus.awaddr);
    end
    @(negedge clk);
    tests++;
    if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin fails++; $display("FAIL awd_c4 got %b required 001", {bus.awvalid, bus.wvalid, bus.bready}); end
    @(negedge clk);
    tests++;
    if (bus.sl_data_ok !== 1'b1) begin fails++; $display("FAIL awd_done got %b required 1", bus.sl_data_ok); end
    aw_wait = 0;
    w_wait = 3;
    issue(1, 2'd2, 32'h3100, 32'h0BADF00D, '0);
    for (int i = 0; i < 40 && exp_done.size() != 0; i++) @(negedge clk);
    tests++;
    if (exp_done.size() != 0) begin fails++; $display("FAIL wd_drain pending got %0d required 0", exp_done.size()); end
    w_wait = 0;
  endtask

  task automatic test_wstrb();
    logic [1:0]  sz[7] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3};
    logic [31:0] ad[7] = '{32'h10, 32'h11, 32'h12, 32'h20, 32'h22, 32'h31, 32'h40};
    for (int i = 0; i < 7; i++) issue(1, sz[i], ad[i], $urandom, '0);
    for (int i = 0; i < 40 && exp_done.size() != 0; i++) @(negedge clk);
    tests++;
    if (exp_done.size() != 0) begin fails++; $display("FAIL wstrb_drain pending got %0d required 0", exp_done.size()); end
  endtask

  task automatic test_back_to_back();
    logic acc = 0;
    push_req(0, 2'd2, 32'h40, '0, 32'h11111111);
    @(posedge clk); #1;
    bus.sl_req = 1; bus.sl_wr = 0; bus.sl_size = 2'd2; bus.sl_addr = 32'h40;
    @(negedge clk);
    tests++;
    if (bus.sl_addr_ok !== 1'b1) begin fails++; $display("FAIL b2b_acc0 got %b required 1", bus.sl_addr_ok); end
    @(posedge clk); #1;
    push_req(1, 2'd2, 32'h44, 32'hCAFEF00D, '0);
    bus.sl_wr = 1; bus.sl_addr = 32'h44; bus.sl_wdata = 32'hCAFEF00D;
    @(negedge clk);
    tests++;
    if (bus.sl_addr_ok !== 1'b0) begin fails++; $display("FAIL b2b_hold_ar got %b required 0", bus.sl_addr_ok); end
    @(negedge clk);
    tests++;
    if (bus.sl_addr_ok !== 1'b0) begin fails++; $display("FAIL b2b_hold_r got %b required 0", bus.sl_addr_ok); end
    @(negedge clk);
    tests++;
    if ({bus.sl_data_ok, bus.sl_addr_ok} !== 2'b11) begin
      fails++; $display("FAIL b2b_overlap got %b required 11", {bus.sl_data_ok, bus.sl_addr_ok});
    end
    @(posedge clk); #1;
    push_req(0, 2'd2, 32'h48, '0, 32'h22222222);
    bus.sl_wr = 0; bus.sl_addr = 32'h48;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (bus.sl_addr_ok) begin acc = 1; break; end end
    @(posedge clk); #1;
    bus.sl_req = 0;
    tests++;
    if (acc !== 1'b1) begin fails++; $display("FAIL b2b_third_accept got %b required 1", acc); end
    for (int i = 0; i < 40 && exp_done.size() != 0; i++) @(negedge clk);
    tests++;
    if (exp_done.size() != 0) begin fails++; $display("FAIL b2b_drain pending got %0d required 0", exp_done.size()); end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    r_hold = 1;
    exp_ar.push_back({32'h50, 3'd2});
    rdata_q.push_back(32'h33333333);
    @(posedge clk); #1;
    bus.sl_req = 1; bus.sl_wr = 0; bus.sl_size = 2'd2; bus.sl_addr = 32'h50;
    @(negedge clk);
    @(posedge clk); #1;
    bus.sl_req = 0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({bus.rready, bus.rvalid} !== 2'b10) begin fails++; $display("FAIL rmid_in_r got %b required 10", {bus.rready, bus.rvalid}); end
    @(posedge clk); #1;
    areset = 0;
    @(posedge clk); #1;
    areset = 1;
    @(negedge clk);
    tests++;
    if ({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.sl_data_ok, bus.sl_addr_ok, bus.sl_rdata} !== 39'b0) begin
      fails++; $display("FAIL rmid_abandon got %b/%h required 0", {bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, bus.sl_data_ok, bus.sl_addr_ok}, bus.sl_rdata);
    end
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (bus.sl_data_ok) pulses++; end
    tests++;
    if (pulses != 0) begin fails++; $display("FAIL rmid_no_done got %0d required 0", pulses); end
    r_hold = 0;
    last_rd = '0;
    resp_val = 2'b10;
    issue(0, 2'd2, 32'h60, '0, 32'h5A5A5A5A);
    for (int i = 0; i < 40 && exp_done.size() != 0; i++) @(negedge clk);
    tests++;
    if (exp_done.size() != 0) begin fails++; $display("FAIL rresp_err_drain pending got %0d required 0", exp_done.size()); end
    resp_val = 2'b00;
  endtask

  initial begin
    bus.sl_req = 0; bus.sl_wr = 0; bus.sl_size = '0; bus.sl_addr = '0; bus.sl_wdata = '0;
    test_reset();
    test_read();
    test_byte_write();
    test_aw_delay();
    test_wstrb();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    tests++;
    if (exp_ar.size() + exp_aw.size() + exp_w.size() + exp_done.size() != 0) begin
      fails++; $display("FAIL final_queues pending got %0d required 0", exp_ar.size() + exp_aw.size() + exp_w.size() + exp_done.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
